// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC APB controller: op and width codes,
// register offsets, STATUS bit positions and the sequencer state encoding.
package ecc_pkg;

  localparam logic [1:0] ECC_ENC  = 2'd0;
  localparam logic [1:0] ECC_DEC  = 2'd1;
  localparam logic [1:0] ECC_FULL = 2'd2;

  localparam logic [1:0] WIDTH_8  = 2'd0;
  localparam logic [1:0] WIDTH_16 = 2'd1;
  localparam logic [1:0] WIDTH_32 = 2'd2;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_DATA_IN = 3'd1;
  localparam logic [2:0] REG_WIDTH   = 3'd2;
  localparam logic [2:0] REG_NOISE   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_RESULT  = 3'd5;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_NUM_ERR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ecc_seq_fsm.sv
// Operation sequencer: launches the core for one cycle, waits for core_done
// under a saturating watchdog, and reports capture strobes to the register bank.
module ecc_seq_fsm
  import ecc_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       launch,
  input  logic [1:0] launch_op,
  input  logic       core_done,
  output logic       busy,
  output logic       core_start,
  output logic [1:0] core_op,
  output logic       cap_done,
  output logic       cap_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= ECC_ENC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && launch) begin
        op_q <= launch_op;
      end
      // Saturate rather than wrap so a mis-sized TIMEOUT can never re-arm
      if (state == START) begin
        cnt <= '0;
      end else if (state == WAIT && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    core_start  = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as a completion
        if (core_done) begin
          cap_done  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          cap_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == START) || (state == WAIT);
  assign core_op = op_q;

endmodule

// File: rtl/ecc_apb_ctrl.sv
// APB3 register bank for the ECC core: configuration registers, CTRL launch,
// STATUS/RESULT capture and a write stall that freezes the core inputs while busy.
module ecc_apb_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT         = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       core_start,
  output logic [1:0]                 core_op,
  output logic [AMBA_WORD-1:0]       core_data,
  output logic [1:0]                 core_width,
  output logic [AMBA_WORD-1:0]       core_noise,
  input  logic                       core_done,
  input  logic [AMBA_WORD-1:0]       core_result,
  input  logic [1:0]                 core_num_err,
  output logic                       irq
);

  logic [AMBA_WORD-1:0] data_in_q, noise_q, result_q, rd_data;
  logic [1:0] width_q, num_err_q;
  logic done_q, timeout_q, err_q;
  logic busy, launch, cap_done, cap_timeout;
  logic [2:0] reg_sel;
  logic wr_commit, rd_commit, ctrl_wr, status_wr;
  logic unused_addr;

  assign reg_sel     = PADDR[4:2];
  assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Any write during an operation is held off until the sequencer is idle
  assign PREADY    = !(PSEL && PENABLE && PWRITE && busy);
  assign wr_commit = PSEL && PENABLE && PWRITE && PREADY;
  assign rd_commit = PSEL && PENABLE && !PWRITE;
  assign ctrl_wr   = wr_commit && (reg_sel == REG_CTRL);
  assign status_wr = wr_commit && (reg_sel == REG_STATUS);
  assign launch    = ctrl_wr && (PWDATA[1:0] inside {ECC_ENC, ECC_DEC, ECC_FULL});

  ecc_seq_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (launch),
    .launch_op  (PWDATA[1:0]),
    .core_done  (core_done),
    .busy       (busy),
    .core_start (core_start),
    .core_op    (core_op),
    .cap_done   (cap_done),
    .cap_timeout(cap_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_q <= '0;
      width_q   <= WIDTH_8;
      noise_q   <= '0;
    end else if (wr_commit) begin
      case (reg_sel)
        REG_DATA_IN: data_in_q <= PWDATA;
        REG_WIDTH:   width_q   <= PWDATA[1:0];
        REG_NOISE:   noise_q   <= PWDATA;
        default: ;
      endcase
    end
  end

  // Later assignments win: hardware sets override a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      num_err_q <= 2'd0;
      result_q  <= '0;
    end else begin
      if (launch) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        num_err_q <= 2'd0;
      end
      if (status_wr) begin
        if (PWDATA[ST_DONE])    done_q    <= 1'b0;
        if (PWDATA[ST_TIMEOUT]) timeout_q <= 1'b0;
        if (PWDATA[ST_ERR])     err_q     <= 1'b0;
      end
      if (cap_done) begin
        done_q    <= 1'b1;
        num_err_q <= core_num_err;
        result_q  <= core_result;
      end
      if (cap_timeout) begin
        timeout_q <= 1'b1;
      end
      if (ctrl_wr && !launch) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA_IN: rd_data = data_in_q;
      REG_WIDTH:   rd_data[1:0] = width_q;
      REG_NOISE:   rd_data = noise_q;
      REG_STATUS: begin
        rd_data[ST_BUSY]          = busy;
        rd_data[ST_DONE]          = done_q;
        rd_data[ST_TIMEOUT]       = timeout_q;
        rd_data[ST_ERR]           = err_q;
        rd_data[ST_NUM_ERR +: 2]  = num_err_q;
      end
      REG_RESULT:  rd_data = result_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PRDATA <= '0;
    end else if (rd_commit) begin
      PRDATA <= rd_data;
    end
  end

  assign core_data  = data_in_q;
  assign core_width = width_q;
  assign core_noise = noise_q;
  assign irq        = done_q || timeout_q;

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Scoreboard bench for ecc_apb_ctrl: APB reads and core launches are predicted by
// a register-level model and checked by independent monitor processes.
module tb_ecc_apb_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        PSEL, PENABLE, PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY;
  logic        core_start, core_done, irq;
  logic [1:0]  core_op, core_width, core_num_err;
  logic [31:0] core_data, core_noise, core_result;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] data;
    logic [1:0]  width;
    logic [31:0] noise;
  } launch_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] val;
  } rd_t;

  launch_t launch_q[$];
  rd_t     rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_data, m_noise, m_result;
  logic [1:0]  m_width, m_nerr;
  logic        m_done, m_to, m_err;

  int          next_lat;
  logic [31:0] next_result;
  logic [1:0]  next_nerr;
  int          last_stall;

  ecc_apb_ctrl #(
    .AMBA_WORD(32),
    .AMBA_ADDR_WIDTH(20),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .core_start(core_start), .core_op(core_op), .core_data(core_data),
    .core_width(core_width), .core_noise(core_noise), .core_done(core_done),
    .core_result(core_result), .core_num_err(core_num_err), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s = '0;
    s[1]   = m_done;
    s[2]   = m_to;
    s[3]   = m_err;
    s[5:4] = m_nerr;
    return s;
  endfunction

  function automatic logic [31:0] expRead(input logic [2:0] idx);
    case (idx)
      3'd1: return m_data;
      3'd2: return {30'd0, m_width};
      3'd3: return m_noise;
      3'd4: return expStatus();
      3'd5: return m_result;
      default: return 32'd0;
    endcase
  endfunction

  // One APB transfer; during any stall the core-facing registers must hold still
  task automatic applyStimulus(input bit wr, input logic [2:0] idx, input logic [31:0] wdata,
                               output int stall);
    stall = 0;
    @(negedge clk);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = 20'($urandom);
    PADDR[4:2] = idx;
    PWDATA  = wdata;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    while (!PREADY && stall < 60) begin
      checkOutput("noise_hold", core_noise, m_noise);
      checkOutput("data_hold", core_data, m_data);
      @(posedge clk);
      #1;
      stall++;
    end
    if (!PREADY) checkOutput("pready_bound", 32'(PREADY), 32'd1);
    @(posedge clk);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic doWrite(input logic [2:0] idx, input logic [31:0] d);
    int st;
    bit legal;
    legal = (d[1:0] != 2'd3);
    if (idx == 3'd0 && legal) launch_q.push_back('{op: d[1:0], data: m_data, width: m_width, noise: m_noise});
    applyStimulus(1'b1, idx, d, st);
    last_stall = st;
    case (idx)
      3'd0: begin
        if (!legal) m_err = 1'b1;
        else begin m_done = 1'b0; m_to = 1'b0; m_nerr = 2'd0; end
      end
      3'd1: m_data  = d;
      3'd2: m_width = d[1:0];
      3'd3: m_noise = d;
      3'd4: begin
        if (d[1]) m_done = 1'b0;
        if (d[2]) m_to   = 1'b0;
        if (d[3]) m_err  = 1'b0;
      end
      default: ;
    endcase
    if (idx == 3'd0) checkOutput("start_latency", 32'(core_start), legal ? 32'd1 : 32'd0);
  endtask

  task automatic doRead(input logic [2:0] idx);
    int st;
    rd_q.push_back('{idx: idx, val: expRead(idx)});
    applyStimulus(1'b0, idx, 32'($urandom), st);
  endtask

  // Core completes within the TIMEOUT WAIT cycles when lat is 1..TIMEOUT, otherwise the watchdog fires
  task automatic waitOp(input bit check_lat);
    int n;
    bit ok;
    n = 0;
    while (!irq && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("op_complete", 32'(irq), 32'd1);
    ok = (next_lat >= 1 && next_lat <= TIMEOUT);
    if (check_lat) checkOutput(ok ? "done_latency" : "timeout_latency", 32'(n),
                               ok ? 32'(next_lat + 1) : 32'(TIMEOUT + 1));
    if (ok) begin
      m_done   = 1'b1;
      m_nerr   = next_nerr;
      m_result = next_result;
    end else begin
      m_to = 1'b1;
    end
  endtask

  task automatic modelReset();
    m_data = '0; m_noise = '0; m_result = '0;
    m_width = '0; m_nerr = '0;
    m_done = 1'b0; m_to = 1'b0; m_err = 1'b0;
  endtask

  // Behavioural core: answers a start pulse after next_lat cycles (0 = never)
  initial begin : core_model
    int cd;
    cd = -1;
    core_done = 1'b0;
    core_result = '0;
    core_num_err = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done    = 1'b1;
          core_result  = next_result;
          core_num_err = next_nerr;
          cd = -1;
        end
      end else if (core_start && next_lat > 0) begin
        cd = next_lat;
      end
    end
  end

  initial begin : read_monitor
    rd_t e;
    forever begin
      @(posedge clk);
      if (rst_n && PSEL && PENABLE && !PWRITE) begin
        #1;
        if (rd_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          checkOutput($sformatf("read_reg%0d", e.idx), PRDATA, e.val);
        end
      end
    end
  end

  initial begin : launch_monitor
    launch_t e;
    forever begin
      @(posedge clk);
      #1;
      if (core_start === 1'b1) begin
        if (launch_q.size() == 0) checkOutput("unexpected_start", 32'd1, 32'd0);
        else begin
          e = launch_q.pop_front();
          checkOutput("core_op", 32'(core_op), 32'(e.op));
          checkOutput("core_data", core_data, e.data);
          checkOutput("core_width", 32'(core_width), 32'(e.width));
          checkOutput("core_noise", core_noise, e.noise);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] aborted");
  end

  initial begin : main
    logic [1:0]  op;
    logic [31:0] d;
    rst_n = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    next_lat = 0; next_result = '0; next_nerr = '0; last_stall = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_prdata", PRDATA, 32'd0);
    checkOutput("rst_pready", 32'(PREADY), 32'd1);
    checkOutput("rst_start", 32'(core_start), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) doRead(3'(i));

    $display("[TB] directed encode");
    doWrite(3'd2, 32'd2);
    doWrite(3'd1, 32'h0000_00A5);
    next_lat = 3; next_result = 32'h1234_5678; next_nerr = 2'd0;
    doWrite(3'd0, 32'd0);
    waitOp(1'b1);
    doRead(3'd4);
    doRead(3'd5);
    checkOutput("irq_done", 32'(irq), 32'd1);

    $display("[TB] directed decode + W1C");
    next_lat = 4; next_result = 32'hCAFE_0001; next_nerr = 2'd1;
    doWrite(3'd0, 32'd1);
    waitOp(1'b1);
    doRead(3'd4);
    doWrite(3'd4, 32'h02);
    doRead(3'd4);
    checkOutput("irq_cleared", 32'(irq), 32'd0);

    $display("[TB] write stall while busy");
    next_lat = 6; next_result = 32'h0BAD_F00D; next_nerr = 2'd2;
    doWrite(3'd0, 32'd2);
    doWrite(3'd3, 32'h0000_00FF);
    checkOutput("write_stalled", 32'(last_stall > 0), 32'd1);
    checkOutput("irq_before_commit", 32'(irq), 32'd1);
    waitOp(1'b0);
    doRead(3'd3);
    doRead(3'd4);

    $display("[TB] illegal op");
    doWrite(3'd4, 32'h0E);
    doWrite(3'd0, 32'd3);
    doRead(3'd4);
    doWrite(3'd4, 32'h08);

    $display("[TB] watchdog timeout and done on final cycle");
    next_lat = 0;
    doWrite(3'd0, 32'd0);
    waitOp(1'b1);
    doRead(3'd4);
    doRead(3'd5);
    next_lat = TIMEOUT; next_result = 32'h5555_AAAA; next_nerr = 2'd1;
    doWrite(3'd0, 32'd2);
    waitOp(1'b1);
    doRead(3'd4);
    doRead(3'd5);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) doWrite(3'd1, $urandom);
      if ($urandom_range(0, 2) == 0) doWrite(3'd2, 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) doWrite(3'd3, $urandom);
      op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      next_lat    = $urandom_range(0, TIMEOUT);
      next_result = $urandom;
      next_nerr   = 2'($urandom_range(0, 3));
      d = $urandom;
      d[1:0] = op;
      doWrite(3'd0, d);
      if (op != 2'd3) waitOp(1'b1);
      doRead(3'd4);
      doRead(3'd5);
      if ($urandom_range(0, 1) == 1) begin
        doWrite(3'd4, $urandom);
        doRead(3'd4);
      end
      checkOutput("irq_level", 32'(irq), 32'(m_done | m_to));
      doRead(3'($urandom_range(0, 7)));
    end

    $display("[TB] reset during WAIT");
    doWrite(3'd3, 32'h1357_9BDF);
    next_lat = 8; next_result = 32'hDEAD_BEEF; next_nerr = 2'd2;
    doWrite(3'd0, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_start", 32'(core_start), 32'd0);
    checkOutput("midrst_irq", 32'(irq), 32'd0);
    checkOutput("midrst_prdata", PRDATA, 32'd0);
    checkOutput("midrst_pready", 32'(PREADY), 32'd1);
    checkOutput("midrst_op", 32'(core_op), 32'd0);
    checkOutput("midrst_noise", core_noise, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("stray_done_irq", 32'(irq), 32'd0);
    doRead(3'd4);
    doRead(3'd5);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("launch_queue_drained", 32'(launch_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
